// File: rtl/dm_port_arb_if.sv
// Data-memory port bundle: core and host request channels plus the single memory port.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface dm_port_arb_if;
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        h_req;
    logic        h_we;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_gnt;
    logic        h_rvalid;
    logic [31:0] h_rdata;

    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  h_req, h_we, h_addr, h_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output h_gnt, h_rvalid, h_rdata,
        output m_addr, m_wdata, m_we
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output h_req, h_we, h_addr, h_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  m_addr, m_wdata, m_we
    );
endinterface

// File: rtl/dm_port_arb.sv
// Core/host arbiter for one data-memory port; grant and access are same-cycle, read data 1 cycle later.
// A losing requester holds its request; host is forced in after HOST_WAIT denials, bursts capped at HOST_BURST.
module dm_port_arb #(
    parameter int HOST_WAIT  = 3,
    parameter int HOST_BURST = 2
) (
    input  logic         clk,
    input  logic         rst_f,
    dm_port_arb_if.slave bus
);
    localparam int MAXP = (HOST_WAIT > HOST_BURST) ? HOST_WAIT : HOST_BURST;
    localparam int CW   = ($clog2(MAXP + 1) > 4) ? $clog2(MAXP + 1) : 4;
    localparam logic [CW-1:0] WAIT_V  = CW'(HOST_WAIT);
    localparam logic [CW-1:0] BURST_V = CW'(HOST_BURST);

    logic [CW-1:0] starve_q, starve_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          c_rvalid_q, h_rvalid_q;
    logic [31:0]   c_rdata_q, h_rdata_q;
    logic          c_gnt, h_gnt, host_prio;

    always_comb begin
        host_prio = (starve_q == WAIT_V) || ((burst_q != '0) && (burst_q < BURST_V));
        c_gnt     = 1'b0;
        h_gnt     = 1'b0;
        if (!rst_f) begin
            if (bus.c_req && bus.h_req) begin
                h_gnt = host_prio;
                c_gnt = !host_prio;
            end else begin
                c_gnt = bus.c_req;
                h_gnt = bus.h_req;
            end
        end
    end

    // Both counters saturate, so they can never wrap back into a priority window.
    always_comb begin
        starve_d = starve_q;
        if (!bus.h_req || h_gnt) begin
            starve_d = '0;
        end else if (starve_q < WAIT_V) begin
            starve_d = starve_q + 1'b1;
        end

        burst_d = burst_q;
        if (!bus.c_req || c_gnt) begin
            burst_d = '0;
        end else if (h_gnt && (burst_q < BURST_V)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            starve_q   <= '0;
            burst_q    <= '0;
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            c_rvalid_q <= c_gnt && !bus.c_we;
            h_rvalid_q <= h_gnt && !bus.h_we;
            if (c_gnt && !bus.c_we) begin
                c_rdata_q <= bus.m_rdata;
            end
            if (h_gnt && !bus.h_we) begin
                h_rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.c_gnt   = c_gnt;
    assign bus.h_gnt   = h_gnt;
    assign bus.m_addr  = c_gnt ? bus.c_addr  : (h_gnt ? bus.h_addr  : 16'h0000);
    assign bus.m_wdata = c_gnt ? bus.c_wdata : (h_gnt ? bus.h_wdata : 32'h0000_0000);
    assign bus.m_we    = c_gnt ? bus.c_we    : (h_gnt && bus.h_we);

    // A read granted just before reset must not surface while reset is held.
    assign bus.c_rvalid = c_rvalid_q && !rst_f;
    assign bus.h_rvalid = h_rvalid_q && !rst_f;
    assign bus.c_rdata  = rst_f ? 32'h0000_0000 : c_rdata_q;
    assign bus.h_rdata  = rst_f ? 32'h0000_0000 : h_rdata_q;
endmodule
